// File: rtl/cpu_run_ctrl.sv
// Run/load sequencer between the program RAM and the SAP core: owns CPU reset and
// clock-enable, and arbitrates the single RAM port between the byte loader and the CPU.
//
// state  | meaning
// IDLE   | CPU held in reset, loader registers own the RAM port
// LOAD   | accepting loader bytes at the load pointer
// RUN    | CPU out of reset, clock-enable pulsed every CLK_DIV cycles
// HALTED | CPU stopped but out of reset so its state stays observable
module cpu_run_ctrl #(
   parameter int ADDR_W  = 4,
   parameter int DATA_W  = 8,
   parameter int CLK_DIV = 4
) (
   input  logic              clk,
   input  logic              reset_n_i,
   input  logic              ld_start_i,
   input  logic              ld_valid_i,
   input  logic [DATA_W-1:0] ld_data_i,
   output logic              ld_ready_o,
   input  logic              run_i,
   input  logic              pause_i,
   input  logic              cpu_halt_i,
   input  logic              cpu_we_i,
   input  logic [ADDR_W-1:0] cpu_addr_i,
   input  logic [DATA_W-1:0] cpu_data_i,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_data_o,
   output logic              cpu_reset_o,
   output logic              cpu_clk_en_o,
   output logic [1:0]        state_o
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_LOAD   = 2'd1,
      S_RUN    = 2'd2,
      S_HALTED = 2'd3
   } state_t;

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [ADDR_W-1:0] PTR_LAST = '1;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   ptr_q, ptr_d;
   logic [DIV_W-1:0]    div_q, div_d;
   logic                wr_we_q, wr_we_d;
   logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
   logic [DATA_W-1:0]   wr_data_q, wr_data_d;
   logic                cpu_reset_q, cpu_reset_d;
   logic                clk_en_q, clk_en_d;
   logic                ld_accept;

   always_ff @(posedge clk or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q     <= S_IDLE;
         ptr_q       <= '0;
         div_q       <= '0;
         wr_we_q     <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
         cpu_reset_q <= 1'b1;
         clk_en_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         div_q       <= div_d;
         wr_we_q     <= wr_we_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
         cpu_reset_q <= cpu_reset_d;
         clk_en_q    <= clk_en_d;
      end
   end

   // A restart pulse in LOAD takes the cycle, so a byte offered alongside it is dropped.
   assign ld_accept = (state_q == S_LOAD) && ld_valid_i && !ld_start_i;

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      div_d     = div_q;
      wr_we_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      unique case (state_q)
         S_IDLE: begin
            if (ld_start_i) begin
               state_d = S_LOAD;
               ptr_d   = '0;
            end else if (run_i) begin
               state_d = S_RUN;
               div_d   = '0;
            end
         end
         S_LOAD: begin
            if (ld_start_i) begin
               ptr_d = '0;
            end else if (ld_accept) begin
               wr_we_d   = 1'b1;
               wr_addr_d = ptr_q;
               wr_data_d = ld_data_i;
               ptr_d     = ptr_q + 1'b1;
               if (ptr_q == PTR_LAST) state_d = S_IDLE;
            end
         end
         S_RUN: begin
            if (ld_start_i) begin
               state_d = S_LOAD;
               ptr_d   = '0;
            end else if (cpu_halt_i) begin
               state_d = S_HALTED;
            end else if (!pause_i) begin
               div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
            end
         end
         S_HALTED: begin
            if (ld_start_i) begin
               state_d = S_LOAD;
               ptr_d   = '0;
            end else if (run_i) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      cpu_reset_d = (state_d == S_IDLE) || (state_d == S_LOAD);
      clk_en_d    = (state_q == S_RUN) && (state_d == S_RUN) && !pause_i && (div_q == DIV_LAST);
   end

   always_comb begin
      ld_ready_o   = (state_q == S_LOAD);
      cpu_reset_o  = cpu_reset_q;
      state_o      = state_q;
      cpu_clk_en_o = clk_en_q && (state_q == S_RUN) && !pause_i && !cpu_halt_i;
      if ((state_q == S_IDLE) || (state_q == S_LOAD)) begin
         mem_we_o   = wr_we_q;
         mem_addr_o = wr_addr_q;
         mem_data_o = wr_data_q;
      end else begin
         mem_we_o   = cpu_we_i;
         mem_addr_o = cpu_addr_i;
         mem_data_o = cpu_data_i;
      end
   end

endmodule
